// File: rtl/dac_ramp_stage.sv
// Output conditioning for the two-channel DAC stream: shared fade ramp, offset, saturation.
// Define DAC_CLIP_FLAG_EN to build the sticky per-channel clip flags.
module dac_ramp_stage #(
    parameter int AXIS_TDATA_OUT_WIDTH = 32,
    parameter int DAC_WIDTH            = 14,
    parameter int RAMP_WIDTH           = 16
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [AXIS_TDATA_OUT_WIDTH-1:0]   s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              ramp_start,
    input  logic                              ramp_stop,
    input  logic [RAMP_WIDTH-1:0]             ramp_step,
    input  logic [AXIS_TDATA_OUT_WIDTH/2-1:0] offset_A,
    input  logic [AXIS_TDATA_OUT_WIDTH/2-1:0] offset_B,
    output logic [AXIS_TDATA_OUT_WIDTH-1:0]   m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic [1:0]                        ramp_state,
    output logic                              ramp_done,
    output logic [1:0]                        clip_flags
);
    localparam int HW = AXIS_TDATA_OUT_WIDTH / 2;
    localparam int FW = RAMP_WIDTH + 1;
    localparam int PW = HW + FW + 1;
    localparam int SW = HW + 2;

    localparam logic [FW-1:0] UNITY = {1'b1, {RAMP_WIDTH{1'b0}}};
    localparam logic signed [SW-1:0] SAT_HI = SW'(2 ** (DAC_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        HOLD = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [FW-1:0]   f, f_nxt;
    logic            done_nxt;
    logic [FW-1:0]   step_ext;
    logic [FW:0]     f_inc;

    assign step_ext = {1'b0, ramp_step};
    assign f_inc    = {1'b0, f} + {1'b0, step_ext};

    always_comb begin
        state_nxt = state;
        f_nxt     = f;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                f_nxt = '0;
                if (ramp_start && !ramp_stop) state_nxt = UP;
            end
            UP: begin
                if (ramp_stop) begin
                    state_nxt = DOWN;
                end else if (f_inc >= {1'b0, UNITY}) begin
                    f_nxt     = UNITY;
                    state_nxt = HOLD;
                end else begin
                    f_nxt = f_inc[FW-1:0];
                end
            end
            HOLD: begin
                f_nxt = UNITY;
                if (ramp_stop) state_nxt = DOWN;
            end
            DOWN: begin
                // a restart resumes the fade-in from wherever the fade-out got to
                if (ramp_start && !ramp_stop) begin
                    state_nxt = UP;
                end else if (ramp_step != '0) begin
                    if (f <= step_ext) begin
                        f_nxt     = '0;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        f_nxt = f - step_ext;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= IDLE;
            f         <= '0;
            ramp_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            f         <= f_nxt;
            ramp_done <= done_nxt;
        end
    end

    assign ramp_state = state;

    logic signed [HW-1:0] s1_a, s1_b;
    logic [FW-1:0]        s1_f;
    logic                 s1_v, s2_v;
    logic signed [SW-1:0] s2_a, s2_b;
    logic signed [PW-1:0] prod_a, prod_b;
    logic signed [SW-1:0] sum_a, sum_b;
    logic signed [SW-1:0] sat_a, sat_b;
    logic                 hi_a, lo_a, hi_b, lo_b;

    assign prod_a = PW'(s1_a) * PW'($signed({1'b0, s1_f}));
    assign prod_b = PW'(s1_b) * PW'($signed({1'b0, s1_f}));

    assign sum_a = s2_a + SW'($signed(offset_A));
    assign sum_b = s2_b + SW'($signed(offset_B));

    assign hi_a = sum_a > SAT_HI;
    assign lo_a = sum_a < SAT_LO;
    assign hi_b = sum_b > SAT_HI;
    assign lo_b = sum_b < SAT_LO;

    always_comb begin
        sat_a = sum_a;
        sat_b = sum_b;
        if (hi_a) sat_a = SAT_HI;
        if (lo_a) sat_a = SAT_LO;
        if (hi_b) sat_b = SAT_HI;
        if (lo_b) sat_b = SAT_LO;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            s1_a          <= '0;
            s1_b          <= '0;
            s1_f          <= '0;
            s1_v          <= 1'b0;
            s2_a          <= '0;
            s2_b          <= '0;
            s2_v          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            s1_a          <= s_axis_tdata[HW-1:0];
            s1_b          <= s_axis_tdata[2*HW-1:HW];
            s1_f          <= f;
            s1_v          <= s_axis_tvalid;
            s2_a          <= SW'(prod_a >>> RAMP_WIDTH);
            s2_b          <= SW'(prod_b >>> RAMP_WIDTH);
            s2_v          <= s1_v;
            // clamped values already fit HW bits sign-extended
            m_axis_tdata  <= {sat_b[HW-1:0], sat_a[HW-1:0]};
            m_axis_tvalid <= s2_v;
        end
    end

`ifdef DAC_CLIP_FLAG_EN
    logic [1:0] clip_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            clip_q <= 2'b00;
        end else if (ramp_start) begin
            clip_q <= 2'b00;
        end else if (s2_v) begin
            clip_q <= clip_q | {hi_b | lo_b, hi_a | lo_a};
        end
    end

    assign clip_flags = clip_q;
`else
    assign clip_flags = 2'b00;
`endif

endmodule

// File: tb/tb_dac_ramp_stage.sv
// Bench for dac_ramp_stage: per-cycle vector table with expected state/factor,
// plus a scoreboard queue predicting the 3-cycle-delayed output data.
module tb_dac_ramp_stage;
    logic        clk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        ramp_start;
    logic        ramp_stop;
    logic [15:0] ramp_step;
    logic [15:0] offset_A;
    logic [15:0] offset_B;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic [1:0]  ramp_state;
    logic        ramp_done;
    logic [1:0]  clip_flags;

    dac_ramp_stage dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .ramp_start   (ramp_start),
        .ramp_stop    (ramp_stop),
        .ramp_step    (ramp_step),
        .offset_A     (offset_A),
        .offset_B     (offset_B),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .ramp_state   (ramp_state),
        .ramp_done    (ramp_done),
        .clip_flags   (clip_flags)
    );

    always #4 clk = ~clk;

    typedef struct {
        bit          rstn;
        bit          start;
        bit          stop;
        logic [15:0] step;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] oa;
        logic [15:0] ob;
        bit          valid;
        logic [1:0]  es;
        logic [16:0] ef;
        bit          ed;
    } vec_t;

    typedef struct {
        bit          v;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] f;
    } ent_t;

    vec_t        vt[$];
    ent_t        sb[$];
    logic [16:0] cur_f;
    logic [1:0]  exp_clip;
    int          n_chk;
    int          n_pass;

    function automatic vec_t mk(bit rn, bit st, bit sp, int step,
                                int a, int b, int oa, int ob, bit v,
                                int es, int ef, bit ed);
        vec_t r;
        r.rstn  = rn;
        r.start = st;
        r.stop  = sp;
        r.step  = 16'(step);
        r.a     = 16'(a);
        r.b     = 16'(b);
        r.oa    = 16'(oa);
        r.ob    = 16'(ob);
        r.valid = v;
        r.es    = 2'(es);
        r.ef    = 17'(ef);
        r.ed    = ed;
        return r;
    endfunction

    function automatic logic [15:0] exp_ch(input logic [15:0] x,
                                           input logic [16:0] f,
                                           input logic [15:0] off,
                                           output bit clip);
        longint pr;
        longint s;
        pr = longint'($signed(x)) * longint'(f);
        s = (pr >>> 16) + longint'($signed(off));
        clip = (s > 8191) || (s < -8192);
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
        return 16'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)",
                      name, act, exp, $time);
    endtask

    task automatic apply(input vec_t v);
        ent_t        e;
        ent_t        z;
        bit          ca, cb;
        logic [15:0] ea, eb;
        logic [1:0]  want_clip;
        aresetn       = v.rstn;
        ramp_start    = v.start;
        ramp_stop     = v.stop;
        ramp_step     = v.step;
        s_axis_tdata  = {v.b, v.a};
        s_axis_tvalid = v.valid;
        offset_A      = v.oa;
        offset_B      = v.ob;
        e.v = v.valid;
        e.a = v.a;
        e.b = v.b;
        e.f = cur_f;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!v.rstn) begin
            chk("rst_data", m_axis_tdata, 32'h0);
            chk("rst_valid", 32'(m_axis_tvalid), 32'h0);
            chk("rst_clip", 32'(clip_flags), 32'h0);
            z.v = 1'b0;
            z.a = '0;
            z.b = '0;
            z.f = '0;
            sb.delete();
            sb.push_back(z);
            sb.push_back(z);
            exp_clip = 2'b00;
        end else if (sb.size() < 3) begin
            chk("scoreboard_depth", 32'(sb.size()), 32'd3);
        end else begin
            e  = sb.pop_front();
            ea = exp_ch(e.a, e.f, v.oa, ca);
            eb = exp_ch(e.b, e.f, v.ob, cb);
            chk("data", m_axis_tdata, {eb, ea});
            chk("valid", 32'(m_axis_tvalid), 32'(e.v));
            if (v.start) exp_clip = 2'b00;
            else if (e.v) exp_clip = exp_clip | {cb, ca};
`ifdef DAC_CLIP_FLAG_EN
            want_clip = exp_clip;
`else
            want_clip = 2'b00;
`endif
            chk("clip", 32'(clip_flags), 32'(want_clip));
        end
        chk("state", 32'(ramp_state), 32'(v.es));
        chk("done", 32'(ramp_done), 32'(v.ed));
        cur_f      = v.ef;
        ramp_start = 1'b0;
        ramp_stop  = 1'b0;
    endtask

    localparam int A  = 'h1000;
    localparam int B  = 'hF000;
    localparam int S  = 'h4000;
    localparam int U  = 'h10000;

    initial begin
        clk           = 1'b0;
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        ramp_start    = 1'b0;
        ramp_stop     = 1'b0;
        ramp_step     = '0;
        offset_A      = '0;
        offset_B      = '0;
        cur_f         = '0;
        exp_clip      = 2'b00;
        n_chk         = 0;
        n_pass        = 0;

        // idle, no ramp; stop is ignored in IDLE
        repeat (4) vt.push_back(mk(1,0,0,S,A,B,0,0,1, 0,0,0));
        vt.push_back(mk(1,0,1,S,A,B,0,0,1, 0,0,0));
        // ramp up to unity, start ignored in HOLD
        vt.push_back(mk(1,1,0,S,A,B,0,0,1, 1,0,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 1,'h4000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 1,'h8000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 1,'hC000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 2,U,0));
        vt.push_back(mk(1,1,0,S,A,B,0,0,1, 2,U,0));
        repeat (3) vt.push_back(mk(1,0,0,S,A,B,0,0,1, 2,U,0));
        // ramp down with done pulse
        vt.push_back(mk(1,0,1,S,A,B,0,0,1, 3,U,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 3,'hC000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 3,'h8000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 3,'h4000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 0,0,1));
        repeat (3) vt.push_back(mk(1,0,0,S,A,B,0,0,1, 0,0,0));
        // stop from UP, then resume from DOWN
        vt.push_back(mk(1,1,0,S,A,B,0,0,1, 1,0,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 1,'h4000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 1,'h8000,0));
        vt.push_back(mk(1,0,1,S,A,B,0,0,1, 3,'h8000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 3,'h4000,0));
        vt.push_back(mk(1,1,0,S,A,B,0,0,1, 1,'h4000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 1,'h8000,0));
        // start+stop collision in UP, then in IDLE
        vt.push_back(mk(1,1,1,S,A,B,0,0,1, 3,'h8000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 3,'h4000,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 0,0,1));
        vt.push_back(mk(1,1,1,S,A,B,0,0,1, 0,0,0));
        vt.push_back(mk(1,0,0,S,A,B,0,0,1, 0,0,0));
        // zero step holds; uneven step clamps at unity
        vt.push_back(mk(1,1,0,0,A,B,0,0,1, 1,0,0));
        vt.push_back(mk(1,0,0,0,A,B,0,0,1, 1,0,0));
        vt.push_back(mk(1,0,0,0,A,B,0,0,0, 1,0,0));
        vt.push_back(mk(1,0,0,'h6000,A,B,0,0,1, 1,'h6000,0));
        vt.push_back(mk(1,0,0,'h6000,A,B,0,0,1, 1,'hC000,0));
        vt.push_back(mk(1,0,0,'h6000,A,B,0,0,1, 2,U,0));
        vt.push_back(mk(1,0,0,'h6000,A,B,0,0,1, 2,U,0));
        // saturation at unity, sticky flags, cleared by start
        repeat (5) vt.push_back(mk(1,0,0,0,'h7FFF,'h8000,'h0100,0,1, 2,U,0));
        repeat (3) vt.push_back(mk(1,0,0,0,A,B,0,0,1, 2,U,0));
        vt.push_back(mk(1,1,0,0,A,B,0,0,1, 2,U,0));
        repeat (3) vt.push_back(mk(1,0,0,0,A,B,0,0,1, 2,U,0));
        vt.push_back(mk(1,0,1,'h8000,A,B,0,0,1, 3,U,0));
        vt.push_back(mk(1,0,0,'h8000,A,B,0,0,1, 3,'h8000,0));
        vt.push_back(mk(1,0,0,'h8000,A,B,0,0,1, 0,0,1));
        vt.push_back(mk(1,0,0,'h8000,A,B,0,0,1, 0,0,0));
        // idle rests at offset level; large negative offset clips
        repeat (4) vt.push_back(mk(1,0,0,S,A,B,'h0100,'hFF00,1, 0,0,0));
        repeat (4) vt.push_back(mk(1,0,0,S,A,B,'h0100,'h8000,1, 0,0,0));
        repeat (3) vt.push_back(mk(1,0,0,S,A,B,0,0,1, 0,0,0));

        apply(mk(0,0,0,0,0,0,0,0,0, 0,0,0));
        apply(mk(0,0,0,0,0,0,0,0,0, 0,0,0));
        foreach (vt[i]) apply(vt[i]);

        // reset while ramping up at f = 0x8000 aborts and flushes
        apply(mk(1,1,0,S,A,B,0,0,1, 1,0,0));
        apply(mk(1,0,0,S,A,B,0,0,1, 1,'h4000,0));
        apply(mk(1,0,0,S,A,B,0,0,1, 1,'h8000,0));
        chk("pre_rst_busy", 32'(ramp_state), 32'd1);
        apply(mk(0,0,0,S,A,B,0,0,1, 0,0,0));
        repeat (5) apply(mk(1,0,0,S,A,B,0,0,1, 0,0,0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dac_ramp_stage.md
# dac_ramp_stage

Output conditioning stage placed directly downstream of `signal_generator`. It consumes the packed two-channel sample stream `{B, A}`, then per channel:
- applies a shared, software-triggered amplitude ramp (fade-in/fade-out envelope),
- adds a per-channel offset,
- saturates to the DAC range.

It feeds the DAC output interface and prevents hard steps on the coils when a sequence starts or stops.

## Interface
Parameters:
- `AXIS_TDATA_OUT_WIDTH`, 32, packed stream width; each channel is half of it.
- `DAC_WIDTH`, 14, DAC resolution used for saturation.
- `RAMP_WIDTH`, 16, width of `ramp_step`. The internal factor is `RAMP_WIDTH+1` bits wide.

Ports:
- `clk`  in  1  sample clock, 125 MHz.
- `aresetn`  in  1  synchronous reset, active low.
- `s_axis_tdata`  in  32  input samples, `{B[15:0], A[15:0]}`, signed two's complement.
- `s_axis_tvalid`  in  1  input valid.
- `ramp_start`  in  1  single-cycle pulse; begin or resume ramp-up.
- `ramp_stop`  in  1  single-cycle pulse; begin ramp-down.
- `ramp_step`  in  16  unsigned factor increment/decrement per clock.
- `offset_A`, `offset_B`  in  16 each  signed offsets added after scaling.
- `m_axis_tdata`  out  32  `{B, A}`, each 14-bit saturated and sign-extended to 16 bits.
- `m_axis_tvalid`  out  1  output valid.
- `ramp_state`  out  2  current FSM state.
- `ramp_done`  out  1  one-cycle pulse when ramp-down completes.
- `clip_flags`  out  2  sticky saturation flags: `[1]` = B, `[0]` = A.

## Operation
- One ramp FSM and one factor register `f` (17 bits, range 0 to 0x10000) are shared by both channels. `f = 0x10000` means unity gain.
- FSM states:
  - IDLE = 0: `f = 0`.
    - `ramp_start` -> UP.
    - `ramp_stop` is ignored.
  - UP = 1: `f <= min(f + ramp_step, 0x10000)`.
    - Enters HOLD on the same edge that `f` reaches 0x10000.
    - `ramp_stop` -> DOWN; `f` is not updated on that edge.
  - HOLD = 2: `f = 0x10000`.
    - `ramp_stop` -> DOWN.
    - `ramp_start` is ignored.
  - DOWN = 3: `f <= max(f - ramp_step, 0)`.
    - Enters IDLE on the same edge that `f` reaches 0; `ramp_done` = 1 for exactly the following cycle.
    - `ramp_start` -> UP, resuming from the current `f`.
- `ramp_start` and `ramp_stop` in the same cycle: stop wins (UP/HOLD -> DOWN; IDLE stays IDLE; DOWN stays DOWN).
- `ramp_step = 0`: `f` holds its value and the state does not change, except via start/stop.
- `f` updates every clock, independent of `s_axis_tvalid`.
- Datapath per channel, with `x` = signed 16-bit sample:
  - `p = (x * f) >>> 16`, using a signed × unsigned 17-bit product and an arithmetic shift.
  - `s = p + offset`, computed 18 bits wide with no intermediate overflow.
  - Output = `s` clamped to [-8192, 8191], then sign-extended to 16 bits.
- In IDLE the output equals the saturated offset, so the DAC rests at the offset level.
- Clip flag for a channel is set when that channel's clamp is active and the stage-3 sample is valid. It clears on reset or `ramp_start`.

## Timing
- Pipeline: 3 registered stages.
  - Stage 1: capture sample and the current `f`.
  - Stage 2: multiply.
  - Stage 3: add and saturate.
- A sample presented at cycle n, with `f` as registered at n, appears on `m_axis_tdata` at n+3.
- `m_axis_tvalid` is `s_axis_tvalid` delayed by 3 cycles. No backpressure: there is no tready and the stage always accepts input.
- Reset, sampled on the rising edge with `aresetn` = 0, clears all of the following:
  - state = IDLE, `f` = 0, all pipeline registers = 0;
  - `m_axis_tdata` = 0, `m_axis_tvalid` = 0, `ramp_done` = 0, `ramp_state` = 0, `clip_flags` = 0.
- Reset mid-ramp aborts the ramp at once, with no ramp-down, and flushes the pipeline.
- `ramp_state` reflects the registered state, updated on the same edge as `f`.

## Configuration
- `DAC_CLIP_FLAG_EN`
  - Defined: sticky `clip_flags` logic is built as described above.
  - Undefined: `clip_flags` is tied to 2'b00 and no flag registers exist. Saturation itself is always present.

## Test plan
- No ramp: reset, offsets 0, A = 0x1000, B = 0xF000, tvalid = 1 -> output 0x0000/0x0000 from cycle 3, tvalid high from cycle 3, `ramp_state` = 0.
- Ramp-up: `ramp_step` = 0x4000, pulse `ramp_start`, A = 0x1000 constant -> `f` = 0x4000, 0x8000, 0xC000, 0x10000 and A out = 0x0400, 0x0800, 0x0C00, 0x1000 (each 3 cycles after its `f`). `ramp_state` = 2 after the 4th step.
- Ramp-down: from HOLD with step 0x4000, pulse `ramp_stop` -> A out steps 0x0C00, 0x0800, 0x0400, 0x0000; state 3 then 0; `ramp_done` high exactly one cycle.
- Saturation: HOLD, A = 0x7FFF, B = 0x8000, offset_A = 0x0100 -> A out 0x1FFF, B out 0xE000; `clip_flags` = 2'b11 with `DAC_CLIP_FLAG_EN`, 2'b00 without. Flags clear on the next `ramp_start`.
- Collision: in UP, assert `ramp_start` and `ramp_stop` together -> state 3 next cycle. In IDLE, same stimulus -> state stays 0.
- Reset mid-UP (`f` = 0x8000): drop `aresetn` for 1 cycle -> next cycle state 0, `f` 0, tvalid 0, data 0.
